// File: rtl/ex_agu_pipe.sv
// ex_agu_pipe: two-stage carry-select address generator, Addr = Rm + (ext(Ri) << Sc).
// Stage 1 builds the extended/scaled index and per-segment speculative sums.
// Stage 2 ripples the segment carries, applies the width rule and the predicate.
// ADDR_W and LOW_W are expected to be multiples of SEG_W, and ADDR_W > SEG_W.
module ex_agu_pipe #(
    parameter int ADDR_W = 48,
    parameter int SEG_W  = 16,
    parameter int IDX_W  = 33,
    parameter int LOW_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              inValid,
    input  logic [ADDR_W-1:0] regValRm,
    input  logic [ADDR_W-1:0] regValRi,
    input  logic [7:0]        idUIxt,
    input  logic              regSrT,
    input  logic              addrEnJq,
    output logic              outValid,
    output logic              outSkip,
    output logic [ADDR_W-1:0] regOutAddr,
    output logic              outMisal,
    output logic              outWrap
);
    localparam int NSEG = ADDR_W / SEG_W;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'({LOW_W{1'b1}});
    localparam logic [SEG_W:0]    SEG_ONE  = (SEG_W+1)'(1);

    typedef enum logic [1:0] {CC_AL = 2'd0, CC_NV = 2'd1, CC_CT = 2'd2, CC_CF = 2'd3} ccE;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_W = 2'd1, SZ_L = 2'd2, SZ_Q = 2'd3} sizeE;

    // Zero- or sign-extend the index (tag bit never comes from the index), then scale.
    function automatic logic [ADDR_W-1:0] extendIndex(input logic [IDX_W-1:0] ri,
                                                      input logic             zext,
                                                      input logic [1:0]       sc);
        logic signed [IDX_W-1:0]  riS;
        logic signed [ADDR_W-1:0] wideS;
        logic [ADDR_W-1:0]        ext;
        riS   = signed'(ri);
        wideS = riS;
        ext   = unsigned'(wideS);
        ext[ADDR_W-1] = 1'b0;
        if (zext) ext = {{(ADDR_W-IDX_W){1'b0}}, ri};
        return ext << sc;
    endfunction

    logic [ADDR_W-1:0] idxScaled;
    logic              unusedBits;
    assign idxScaled  = extendIndex(regValRi[IDX_W-1:0], idUIxt[2], idUIxt[1:0]);
    assign unusedBits = ^{regValRi[ADDR_W-1:IDX_W], idUIxt[3]};

    logic           vld_p1, t_p1, jq_p1;
    ccE             cc_p1;
    sizeE           size_p1;
    logic [SEG_W:0] sum0_p1 [NSEG];
    logic [SEG_W:0] sum1_p1 [1:NSEG-1];

    // ---- stage 1: extended index, speculative segment sums, op attributes
    // Capture a new op (or bubble) whenever the pipe is not held.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            t_p1    <= 1'b0;
            jq_p1   <= 1'b0;
            cc_p1   <= CC_AL;
            size_p1 <= SZ_B;
            for (int s = 0; s < NSEG; s++) sum0_p1[s] <= '0;
            for (int s = 1; s < NSEG; s++) sum1_p1[s] <= '0;
        end else if (!hold) begin
            vld_p1  <= inValid;
            t_p1    <= regSrT;
            jq_p1   <= addrEnJq;
            cc_p1   <= ccE'(idUIxt[7:6]);
            size_p1 <= sizeE'(idUIxt[5:4]);
            for (int s = 0; s < NSEG; s++)
                sum0_p1[s] <= {1'b0, regValRm[s*SEG_W +: SEG_W]}
                            + {1'b0, idxScaled[s*SEG_W +: SEG_W]};
            for (int s = 1; s < NSEG; s++)
                sum1_p1[s] <= {1'b0, regValRm[s*SEG_W +: SEG_W]}
                            + {1'b0, idxScaled[s*SEG_W +: SEG_W]} + SEG_ONE;
        end
    end

    logic [ADDR_W-1:0] fullSum, resAddr;
    logic              carryTop, carryLow, resWrap, pass, misal;

    // ---- stage 2: carry-select ripple across segments
    // Pick sum1/sum0 per segment from the previous carry; note carries at LOW_W and the top.
    always_comb begin : carryChain
        logic           c;
        logic [SEG_W:0] seg;
        fullSum  = '0;
        carryLow = 1'b0;
        seg      = '0;
        c        = sum0_p1[0][SEG_W];
        fullSum[SEG_W-1:0] = sum0_p1[0][SEG_W-1:0];
        if (LOW_W == SEG_W) carryLow = c;
        for (int s = 1; s < NSEG; s++) begin
            seg = c ? sum1_p1[s] : sum0_p1[s];
            fullSum[s*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            c = seg[SEG_W];
            if ((s + 1) * SEG_W == LOW_W) carryLow = c;
        end
        carryTop = c;
    end

    // Apply the width rule, evaluate the predicate and the alignment check.
    always_comb begin
        resAddr = jq_p1 ? fullSum : (fullSum & LOW_MASK);
        resWrap = jq_p1 ? carryTop : carryLow;
        pass    = 1'b0;
        misal   = 1'b0;
        case (cc_p1)
            CC_AL:   pass = 1'b1;
            CC_NV:   pass = 1'b0;
            CC_CT:   pass = t_p1;
            CC_CF:   pass = ~t_p1;
            default: pass = 1'b0;
        endcase
        case (size_p1)
            SZ_W:    misal = resAddr[0];
            SZ_L:    misal = |resAddr[1:0];
            SZ_Q:    misal = |resAddr[2:0];
            default: misal = 1'b0;
        endcase
    end

    // Register the result; skipped ops zero address and flags, bubbles keep the address.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValid   <= 1'b0;
            outSkip    <= 1'b0;
            regOutAddr <= '0;
            outMisal   <= 1'b0;
            outWrap    <= 1'b0;
        end else if (!hold) begin
            outValid <= vld_p1 & pass;
            outSkip  <= vld_p1 & ~pass;
            outMisal <= vld_p1 & pass & misal;
            outWrap  <= vld_p1 & pass & resWrap;
            if (vld_p1) regOutAddr <= pass ? resAddr : '0;
        end
    end
endmodule

// File: tb/tb_ex_agu_pipe.sv
// Bench for ex_agu_pipe: directed vector table, hold/reset sequences, and
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_ex_agu_pipe;
    logic        clock = 1'b0;
    logic        reset, hold, inValid, regSrT, addrEnJq;
    logic [47:0] regValRm, regValRi, regOutAddr;
    logic [7:0]  idUIxt;
    logic        outValid, outSkip, outMisal, outWrap;

    int tests = 0;
    int failures = 0;

    ex_agu_pipe dut (
        .clock(clock), .reset(reset), .hold(hold), .inValid(inValid),
        .regValRm(regValRm), .regValRi(regValRi), .idUIxt(idUIxt),
        .regSrT(regSrT), .addrEnJq(addrEnJq), .outValid(outValid),
        .outSkip(outSkip), .regOutAddr(regOutAddr), .outMisal(outMisal),
        .outWrap(outWrap)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        vld;
        logic [47:0] rm;
        logic [47:0] ri;
        logic [7:0]  ux;
        logic        t;
        logic        jq;
    } op_t;

    typedef struct {
        logic [47:0] rm;
        logic [47:0] ri;
        logic [7:0]  ux;
        logic        t;
        logic        jq;
        logic        eV;
        logic        eS;
        logic [47:0] eA;
        logic        eM;
        logic        eW;
    } vec_t;

    // Reference model state: the op waiting to emerge and the expected outputs.
    op_t         pend;
    logic        eV, eS, eM, eW;
    logic [47:0] eA;

    // Effective address from first principles using 64-bit integer arithmetic.
    function automatic void refModel(input logic [47:0] rm, input logic [47:0] ri,
                                     input logic [7:0] ux, input logic t, input logic jq,
                                     output logic v, output logic sk, output logic [47:0] a,
                                     output logic mi, output logic wr);
        logic [63:0]        raw, idx, m, s, res, sz;
        logic signed [63:0] sv;
        logic               pass;
        raw = 64'(ri[32:0]);
        if (ux[2]) begin
            idx = raw;
        end else begin
            sv = signed'(raw);
            if (ri[32]) sv = sv - (64'sd1 <<< 33);
            idx = unsigned'(sv) & ((64'd1 << 47) - 64'd1);
        end
        idx = (idx << ux[1:0]) & ((64'd1 << 48) - 64'd1);
        m   = jq ? (64'd1 << 48) : (64'd1 << 32);
        s   = (64'(rm) % m) + (idx % m);
        res = s % m;
        case (ux[7:6])
            2'd0:    pass = 1'b1;
            2'd1:    pass = 1'b0;
            2'd2:    pass = t;
            default: pass = !t;
        endcase
        sz = 64'd1 << ux[5:4];
        if (pass) begin
            v = 1'b1; sk = 1'b0; a = res[47:0];
            mi = (res % sz) != 64'd0;
            wr = s >= m;
        end else begin
            v = 1'b0; sk = 1'b1; a = 48'd0; mi = 1'b0; wr = 1'b0;
        end
    endfunction

    task automatic checkOut(input string name, input logic v, input logic sk,
                            input logic [47:0] a, input logic mi, input logic wr);
        tests++;
        if (outValid !== v || outSkip !== sk || regOutAddr !== a ||
            outMisal !== mi || outWrap !== wr) begin
            failures++;
            $display("FAIL %s: got v=%b s=%b a=%h m=%b w=%b, expected v=%b s=%b a=%h m=%b w=%b",
                     name, outValid, outSkip, regOutAddr, outMisal, outWrap,
                     v, sk, a, mi, wr);
        end
    endtask

    // One clock: advance the model with the values present at the edge, then check.
    task automatic cycle();
        @(posedge clock);
        if (reset) begin
            eV = 1'b0; eS = 1'b0; eA = '0; eM = 1'b0; eW = 1'b0;
            pend.vld = 1'b0;
        end else if (!hold) begin
            if (pend.vld) begin
                refModel(pend.rm, pend.ri, pend.ux, pend.t, pend.jq, eV, eS, eA, eM, eW);
            end else begin
                eV = 1'b0; eS = 1'b0; eM = 1'b0; eW = 1'b0;
            end
            pend = '{inValid, regValRm, regValRi, idUIxt, regSrT, addrEnJq};
        end
        #1;
        checkOut("model", eV, eS, eA, eM, eW);
    endtask

    task automatic setOp(input logic [47:0] rm, input logic [47:0] ri, input logic [7:0] ux,
                         input logic t, input logic jq, input logic v);
        regValRm = rm; regValRi = ri; idUIxt = ux; regSrT = t; addrEnJq = jq; inValid = v;
    endtask

    vec_t vecs [15];

    initial begin
        logic [63:0] r64a, r64b;
        vecs[0]  = '{48'h0000_1000_0000, 48'h10,          8'h37, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0000_1000_0080, 1'b0, 1'b0};
        vecs[1]  = '{48'h0000_0000_FFFF, 48'h1,           8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0000_0001_0000, 1'b0, 1'b0};
        vecs[2]  = '{48'h0000_FFFF_FFFF, 48'h1,           8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0001_0000_0000, 1'b0, 1'b0};
        vecs[3]  = '{48'h10,             48'h1_FFFF_FFFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 48'h8000_0000_000F, 1'b0, 1'b0};
        vecs[4]  = '{48'h10,             48'h1_FFFF_FFFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 48'h0000_0000_000F, 1'b0, 1'b1};
        vecs[5]  = '{48'h100,            48'h4,           8'h84, 1'b0, 1'b1, 1'b0, 1'b1, 48'h0,              1'b0, 1'b0};
        vecs[6]  = '{48'h100,            48'h4,           8'hC4, 1'b0, 1'b1, 1'b1, 1'b0, 48'h104,            1'b0, 1'b0};
        vecs[7]  = '{48'h100,            48'h4,           8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 48'h0,              1'b0, 1'b0};
        vecs[8]  = '{48'h100,            48'h4,           8'h84, 1'b1, 1'b1, 1'b1, 1'b0, 48'h104,            1'b0, 1'b0};
        vecs[9]  = '{48'h1000,           48'h2,           8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 48'h1002,           1'b1, 1'b0};
        vecs[10] = '{48'h1001,           48'h0,           8'h14, 1'b0, 1'b1, 1'b1, 1'b0, 48'h1001,           1'b1, 1'b0};
        vecs[11] = '{48'h1004,           48'h0,           8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 48'h1004,           1'b1, 1'b0};
        vecs[12] = '{48'h100,            48'h1_FFFF_FFFF, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0000_0000_00FC, 1'b0, 1'b1};
        vecs[13] = '{48'hABCD_0000_0010, 48'h20,          8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 48'h30,             1'b0, 1'b0};
        vecs[14] = '{48'h0,              48'hFFFF_0000_0008, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 48'h0001_0000_0008, 1'b0, 1'b0};

        pend = '{1'b0, 48'd0, 48'd0, 8'd0, 1'b0, 1'b0};
        eV = 1'b0; eS = 1'b0; eA = '0; eM = 1'b0; eW = 1'b0;
        reset = 1'b1; hold = 1'b0;
        setOp(48'd0, 48'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOut("resetState", 1'b0, 1'b0, 48'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cycle();

        // Directed vectors: issue one op, then an idle cycle, then compare.
        for (int i = 0; i < 15; i++) begin
            setOp(vecs[i].rm, vecs[i].ri, vecs[i].ux, vecs[i].t, vecs[i].jq, 1'b1);
            cycle();
            inValid = 1'b0;
            cycle();
            checkOut($sformatf("vec%0d", i), vecs[i].eV, vecs[i].eS, vecs[i].eA,
                     vecs[i].eM, vecs[i].eW);
        end

        // Stall: A, B back to back, hold for 3 cycles with a decoy op on the inputs.
        setOp(48'h100, 48'h1, 8'h04, 1'b0, 1'b1, 1'b1);
        cycle();
        setOp(48'h200, 48'h2, 8'h04, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOut("holdA", 1'b1, 1'b0, 48'h101, 1'b0, 1'b0);
        hold = 1'b1;
        setOp(48'h900, 48'h9, 8'h04, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOut($sformatf("holdFrozen%0d", i), 1'b1, 1'b0, 48'h101, 1'b0, 1'b0);
        end
        hold = 1'b0;
        setOp(48'h300, 48'h3, 8'h04, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOut("holdB", 1'b1, 1'b0, 48'h202, 1'b0, 1'b0);
        inValid = 1'b0;
        cycle();
        checkOut("holdC", 1'b1, 1'b0, 48'h303, 1'b0, 1'b0);
        cycle();
        checkOut("idleKeepsAddr", 1'b0, 1'b0, 48'h303, 1'b0, 1'b0);

        // Reset with ops in flight (and hold asserted): nothing stale may emerge.
        setOp(48'h400, 48'h4, 8'h04, 1'b0, 1'b1, 1'b1);
        cycle();
        setOp(48'h500, 48'h5, 8'h04, 1'b0, 1'b1, 1'b1);
        cycle();
        checkOut("preReset", 1'b1, 1'b0, 48'h404, 1'b0, 1'b0);
        setOp(48'h600, 48'h6, 8'h04, 1'b0, 1'b1, 1'b1);
        reset = 1'b1; hold = 1'b1;
        cycle();
        checkOut("rstClear", 1'b0, 1'b0, 48'd0, 1'b0, 1'b0);
        reset = 1'b0; hold = 1'b0; inValid = 1'b0;
        cycle();
        checkOut("rstNoStale1", 1'b0, 1'b0, 48'd0, 1'b0, 1'b0);
        cycle();
        checkOut("rstNoStale2", 1'b0, 1'b0, 48'd0, 1'b0, 1'b0);

        // Randomized traffic with stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            r64a = {$urandom(), $urandom()};
            r64b = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) r64a = r64a | 64'h0000_0000_FFFF_FFF0;
            setOp(r64a[47:0], r64b[47:0], 8'($urandom()), 1'($urandom()), 1'($urandom()),
                  $urandom_range(0, 9) < 7);
            hold  = $urandom_range(0, 4) == 0;
            reset = $urandom_range(0, 99) == 0;
            cycle();
        end
        reset = 1'b0; hold = 1'b0; inValid = 1'b0;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
